// File: rtl/synth_pkg.sv
// Types and constants shared by the synth voice blocks: envelope, mixer and voice allocator.
package synth_pkg;

  localparam int unsigned LEVEL_W = 16;

  typedef logic [LEVEL_W-1:0] level_t;

  localparam level_t LEVEL_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_DECAY,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running pacing counter: tick_o is high for one clock out of every TICK_DIV clocks.
module tick_divider #(
  parameter int unsigned TICK_DIV = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  // A divide-by-one still needs a 1-bit counter; it simply never leaves zero.
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/envelope_generator.sv
// Per-voice ADSR envelope: gate-driven state changes every clock, tick-paced saturating level ramps.
module envelope_generator
  import synth_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1024
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               gate_i,
  input  logic [LEVEL_W-1:0] attack_step_i,
  input  logic [LEVEL_W-1:0] decay_step_i,
  input  logic [LEVEL_W-1:0] sustain_level_i,
  input  logic [LEVEL_W-1:0] release_step_i,
  output logic [LEVEL_W-1:0] level_o,
  output logic               active_o,
  output logic               done_o
);

  env_state_t   state_q, state_d;
  level_t       level_q, level_d;
  logic         active_q;
  logic         done_q, done_d;
  logic         tick;
  logic [LEVEL_W:0] attack_sum;
  logic [LEVEL_W:0] decay_diff;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tick_o  (tick)
  );

  // The decay difference is read as 17-bit two's complement so an overshoot below zero still compares low.
  assign attack_sum = {1'b0, level_q} + {1'b0, attack_step_i};
  assign decay_diff = {1'b0, level_q} - {1'b0, decay_step_i};

  // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    done_d  = 1'b0;
    unique case (state_q)
      ENV_IDLE: begin
        level_d = '0;
        if (gate_i) state_d = ENV_ATTACK;
      end
      ENV_ATTACK: begin
        if (tick) begin
          if (attack_sum >= {1'b0, LEVEL_MAX}) begin
            level_d = LEVEL_MAX;
            state_d = ENV_DECAY;
          end else begin
            level_d = attack_sum[LEVEL_W-1:0];
          end
        end
        if (!gate_i) state_d = ENV_RELEASE;
      end
      ENV_DECAY: begin
        if (tick) begin
          if ($signed(decay_diff) <= $signed({1'b0, sustain_level_i})) begin
            level_d = sustain_level_i;
            state_d = ENV_SUSTAIN;
          end else begin
            level_d = decay_diff[LEVEL_W-1:0];
          end
        end
        if (!gate_i) state_d = ENV_RELEASE;
      end
      ENV_SUSTAIN: begin
        level_d = sustain_level_i;
        if (!gate_i) state_d = ENV_RELEASE;
      end
      ENV_RELEASE: begin
        if (tick) begin
          if (level_q <= release_step_i) begin
            level_d = '0;
            state_d = ENV_IDLE;
          end else begin
            level_d = level_q - release_step_i;
          end
        end
        // A re-pressed key wins over the end of the tail and restarts from the current level.
        if (gate_i) state_d = ENV_ATTACK;
      end
      default: begin
        state_d = ENV_IDLE;
        level_d = '0;
      end
    endcase
    done_d = (state_q == ENV_RELEASE) && (state_d == ENV_IDLE);
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ENV_IDLE;
      level_q  <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      active_q <= (state_d != ENV_IDLE);
      done_q   <= done_d;
    end
  end

  assign level_o  = level_q;
  assign active_o = active_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_envelope_generator.sv
// Scoreboard bench for envelope_generator: one instance at TICK_DIV=1, one at TICK_DIV=4.
module tb_envelope_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        gate1, gate4;
  logic [15:0] a_step, d_step, s_lvl, r_step;
  logic [15:0] lvl1, lvl4;
  logic        act1, act4, done1, done4;

  always #5 clk = ~clk;

  envelope_generator #(.TICK_DIV(1)) dut1 (
    .clk_i           (clk),
    .reset_i         (rst),
    .gate_i          (gate1),
    .attack_step_i   (a_step),
    .decay_step_i    (d_step),
    .sustain_level_i (s_lvl),
    .release_step_i  (r_step),
    .level_o         (lvl1),
    .active_o        (act1),
    .done_o          (done1)
  );

  envelope_generator #(.TICK_DIV(4)) dut4 (
    .clk_i           (clk),
    .reset_i         (rst),
    .gate_i          (gate4),
    .attack_step_i   (a_step),
    .decay_step_i    (d_step),
    .sustain_level_i (s_lvl),
    .release_step_i  (r_step),
    .level_o         (lvl4),
    .active_o        (act4),
    .done_o          (done4)
  );

  typedef struct {
    logic        sel;
    logic [15:0] level;
    logic        active;
    logic        done;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_vec    = 0;

  task automatic check(input string name, input int id, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s vec%0d: got %h expected %h", name, id, got, want);
  endtask

  // Drive one clock of stimulus, then queue the outputs expected after that edge.
  task automatic cyc(input logic r, input logic g1, input logic g4, input logic sel,
                     input logic [15:0] lv, input logic ac, input logic dn);
    exp_t e;
    rst   = r;
    gate1 = g1;
    gate4 = g4;
    @(posedge clk);
    #1;
    e.sel    = sel;
    e.level  = lv;
    e.active = ac;
    e.done   = dn;
    e.id     = n_vec;
    n_vec++;
    sb_q.push_back(e);
  endtask

  task automatic run1(input logic g, input logic [15:0] lv, input logic ac, input logic dn);
    cyc(1'b0, g, 1'b0, 1'b0, lv, ac, dn);
  endtask

  task automatic run4(input logic g, input logic [15:0] lv, input logic ac, input logic dn);
    cyc(1'b0, 1'b0, g, 1'b1, lv, ac, dn);
  endtask

  // Monitor: compares the selected instance on every falling edge with a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.sel) begin
          check("level4",  e.id, lvl4, e.level);
          check("active4", e.id, {15'd0, act4}, {15'd0, e.active});
          check("done4",   e.id, {15'd0, done4}, {15'd0, e.done});
        end else begin
          check("level1",  e.id, lvl1, e.level);
          check("active1", e.id, {15'd0, act1}, {15'd0, e.active});
          check("done1",   e.id, {15'd0, done1}, {15'd0, e.done});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; gate1 = 1'b0; gate4 = 1'b0;
    a_step = 16'h4000; d_step = 16'h1000; s_lvl = 16'h8000; r_step = 16'h2000;

    // Reset held with gate high
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Full ADSR
    run1(1, 16'h0000, 1, 0);
    run1(1, 16'h4000, 1, 0);
    run1(1, 16'h8000, 1, 0);
    run1(1, 16'hC000, 1, 0);
    run1(1, 16'hFFFF, 1, 0);
    for (int i = 0; i < 7; i++) run1(1, 16'hEFFF - 16'(i) * 16'h1000, 1, 0);
    run1(1, 16'h8000, 1, 0);
    run1(1, 16'h8000, 1, 0);
    run1(0, 16'h8000, 1, 0);
    run1(0, 16'h6000, 1, 0);
    run1(0, 16'h4000, 1, 0);
    run1(0, 16'h2000, 1, 0);
    run1(0, 16'h0000, 0, 1);
    run1(0, 16'h0000, 0, 0);

    // Release retrigger, then attack end coinciding with gate low
    run1(1, 16'h0000, 1, 0);
    run1(1, 16'h4000, 1, 0);
    run1(1, 16'h8000, 1, 0);
    run1(1, 16'hC000, 1, 0);
    run1(1, 16'hFFFF, 1, 0);
    for (int i = 0; i < 7; i++) run1(1, 16'hEFFF - 16'(i) * 16'h1000, 1, 0);
    run1(1, 16'h8000, 1, 0);
    run1(0, 16'h8000, 1, 0);
    run1(0, 16'h6000, 1, 0);
    run1(1, 16'h4000, 1, 0);
    run1(1, 16'h8000, 1, 0);
    run1(1, 16'hC000, 1, 0);
    run1(0, 16'hFFFF, 1, 0);
    for (int i = 0; i < 7; i++) run1(0, 16'hDFFF - 16'(i) * 16'h2000, 1, 0);
    run1(0, 16'h0000, 0, 1);
    run1(0, 16'h0000, 0, 0);

    // Release end coinciding with gate high: attack from zero, no done
    run1(1, 16'h0000, 1, 0);
    run1(0, 16'h4000, 1, 0);
    run1(0, 16'h2000, 1, 0);
    run1(1, 16'h0000, 1, 0);
    run1(1, 16'h4000, 1, 0);

    // Saturation
    r_step = 16'hFFFF;
    run1(0, 16'h8000, 1, 0);
    run1(0, 16'h0000, 0, 1);
    run1(0, 16'h0000, 0, 0);
    a_step = 16'hFFFF;
    run1(1, 16'h0000, 1, 0);
    run1(1, 16'hFFFF, 1, 0);
    run1(1, 16'hEFFF, 1, 0);
    run1(0, 16'hDFFF, 1, 0);
    run1(0, 16'h0000, 0, 1);
    run1(0, 16'h0000, 0, 0);
    a_step = 16'h0001;
    run1(1, 16'h0000, 1, 0);
    run1(0, 16'h0001, 1, 0);
    run1(0, 16'h0000, 0, 1);
    run1(0, 16'h0000, 0, 0);

    // Zero attack step holds
    a_step = 16'h0000; r_step = 16'h2000;
    run1(1, 16'h0000, 1, 0);
    run1(1, 16'h0000, 1, 0);
    run1(1, 16'h0000, 1, 0);
    run1(0, 16'h0000, 1, 0);
    run1(0, 16'h0000, 0, 1);
    run1(0, 16'h0000, 0, 0);

    // Sustain at full scale, then live sustain tracking
    a_step = 16'hFFFF; s_lvl = 16'hFFFF;
    run1(1, 16'h0000, 1, 0);
    run1(1, 16'hFFFF, 1, 0);
    run1(1, 16'hFFFF, 1, 0);
    s_lvl = 16'h1234;
    run1(1, 16'h1234, 1, 0);
    r_step = 16'hFFFF;
    run1(0, 16'h1234, 1, 0);
    run1(0, 16'h0000, 0, 1);

    // Mid-note reset during decay at 0xC000
    a_step = 16'hFFFF; d_step = 16'h3FFF; s_lvl = 16'h0000;
    run1(1, 16'h0000, 1, 0);
    run1(1, 16'hFFFF, 1, 0);
    run1(1, 16'hC000, 1, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // TICK_DIV=4: reset above phased the divider so ticks land on the 4th, 8th, 12th edge
    a_step = 16'h1000; r_step = 16'h2000;
    run4(1, 16'h0000, 1, 0);
    run4(1, 16'h0000, 1, 0);
    run4(1, 16'h1000, 1, 0);
    run4(1, 16'h1000, 1, 0);
    run4(1, 16'h1000, 1, 0);
    run4(1, 16'h1000, 1, 0);
    run4(1, 16'h2000, 1, 0);
    run4(0, 16'h2000, 1, 0);
    run4(1, 16'h2000, 1, 0);
    run4(1, 16'h2000, 1, 0);
    run4(1, 16'h3000, 1, 0);
    run4(0, 16'h3000, 1, 0);

    repeat (2) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
